// File: rtl/bounce_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bounce_engine                                                |
// | Description : Bouncing-object demo engine. Moves N_OBJ square objects     |
// |               around the visible area once per frame, bouncing them off    |
// |               the edges. Two debounced pushbuttons raise and lower the    |
// |               speed. Each pixel gets a registered colour, and every        |
// |               bounce produces a sound code that is held for SND_FRAMES.   |
// | Ports       : clk        - system clock                                    |
// |               clr        - synchronous active-high reset                  |
// |               x_px/y_px  - current pixel coordinate from the VGA timing    |
// |               inc_vel    - raw pushbutton, speed up                        |
// |               dec_vel    - raw pushbutton, speed down                      |
// |               color_px   - RGB for the current pixel (1 clk latency)       |
// |               code_sound - 01 horiz, 10 vert, 11 corner, 00 silent        |
// |               mute       - high while code_sound is 00                     |
// |               vel        - live speed setting                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bounce_engine #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int N_OBJ      = 2,
  parameter int OBJ_W      = 32,
  parameter int OBJ_H      = 32,
  parameter int VEL_MAX    = 7,
  parameter int DEB_CYC    = 120000,
  parameter int SND_FRAMES = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  input  logic       inc_vel,
  input  logic       dec_vel,
  output logic [2:0] color_px,
  output logic [1:0] code_sound,
  output logic       mute,
  output logic [3:0] vel
);

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - OBJ_W);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - OBJ_H);
  localparam int          DEB_W = $clog2(DEB_CYC + 1);
  localparam int          SND_W = $clog2(SND_FRAMES + 1);

  // ---------------------------------------------------------------------------
  // Frame tick: rising edge of "coordinate is the first blanking position".
  // ---------------------------------------------------------------------------
  logic at_end;
  logic end_seen_q, end_seen_d;
  logic frame_tick;

  always_comb begin
    at_end     = (x_px == 10'(H_ACTIVE)) && (y_px == 10'(V_ACTIVE));
    end_seen_d = at_end;
    frame_tick = at_end && !end_seen_q && !clr;
  end

  always_ff @(posedge clk) begin
    if (clr) end_seen_q <= 1'b0;
    else     end_seen_q <= end_seen_d;
  end

  // ---------------------------------------------------------------------------
  // Button synchronisers and debouncers. Bit 0 = inc, bit 1 = dec.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    DB_IDLE  = 2'd0,
    DB_COUNT = 2'd1,
    DB_HELD  = 2'd2
  } db_state_t;

  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;

  assign btn_raw = {dec_vel, inc_vel};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0]       sync_q, sync_d;
    db_state_t        state_q, state_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             pulse;

    // The IDLE cycle that sees the input high counts as the first of the
    // DEB_CYC consecutive high cycles, hence COUNT starts at 1.
    always_comb begin
      sync_d  = {sync_q[0], btn_raw[b]};
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse   = 1'b0;
      case (state_q)
        DB_IDLE: begin
          if (sync_q[1]) begin
            state_d = DB_COUNT;
            cnt_d   = DEB_W'(1);
          end
        end
        DB_COUNT: begin
          if (!sync_q[1]) begin
            state_d = DB_IDLE;
          end else if (cnt_q == DEB_W'(DEB_CYC - 1)) begin
            state_d = DB_HELD;
            pulse   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DB_HELD: begin
          if (!sync_q[1]) state_d = DB_IDLE;
        end
        default: state_d = DB_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (clr) begin
        sync_q  <= 2'b00;
        state_q <= DB_IDLE;
        cnt_q   <= '0;
      end else begin
        sync_q  <= sync_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign btn_pulse[b] = pulse & ~clr;
  end

  // ---------------------------------------------------------------------------
  // Speed register (simultaneous inc/dec cancel out).
  // ---------------------------------------------------------------------------
  logic [3:0] vel_q, vel_d;

  always_comb begin
    vel_d = vel_q;
    if (btn_pulse[0] && !btn_pulse[1]) begin
      if (vel_q < 4'(VEL_MAX)) vel_d = vel_q + 4'd1;
    end else if (btn_pulse[1] && !btn_pulse[0]) begin
      if (vel_q != 4'd0) vel_d = vel_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) vel_q <= 4'd1;
    else     vel_q <= vel_d;
  end

  // ---------------------------------------------------------------------------
  // Objects. Positions only move on frame_tick, so the speed seen there is the
  // value latched for the whole frame. dx/dy: 1 = right/down.
  // ---------------------------------------------------------------------------
  logic [N_OBJ-1:0] hb;
  logic [N_OBJ-1:0] vb;
  logic [N_OBJ-1:0] hit;

  for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic [10:0] x_sum, y_sum;
    logic        h_hit, v_hit;

    always_comb begin
      x_sum = {1'b0, x_q} + {7'd0, vel_q};
      y_sum = {1'b0, y_q} + {7'd0, vel_q};
      x_d   = x_q;
      y_d   = y_q;
      dx_d  = dx_q;
      dy_d  = dy_q;
      h_hit = 1'b0;
      v_hit = 1'b0;
      if (frame_tick) begin
        if (dx_q) begin
          if (x_sum >= X_MAX) begin
            x_d = X_MAX[9:0]; dx_d = 1'b0; h_hit = 1'b1;
          end else begin
            x_d = x_sum[9:0];
          end
        end else begin
          if ({1'b0, x_q} < {7'd0, vel_q}) begin
            x_d = 10'd0; dx_d = 1'b1; h_hit = 1'b1;
          end else begin
            x_d = x_q - {6'd0, vel_q};
          end
        end
        if (dy_q) begin
          if (y_sum >= Y_MAX) begin
            y_d = Y_MAX[9:0]; dy_d = 1'b0; v_hit = 1'b1;
          end else begin
            y_d = y_sum[9:0];
          end
        end else begin
          if ({1'b0, y_q} < {7'd0, vel_q}) begin
            y_d = 10'd0; dy_d = 1'b1; v_hit = 1'b1;
          end else begin
            y_d = y_q - {6'd0, vel_q};
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (clr) begin
        x_q  <= 10'(16 + 64 * i);
        y_q  <= 10'(16 + 48 * i);
        dx_q <= ((i % 2) == 0);
        dy_q <= 1'b1;
      end else begin
        x_q  <= x_d;
        y_q  <= y_d;
        dx_q <= dx_d;
        dy_q <= dy_d;
      end
    end

    assign hb[i]  = h_hit;
    assign vb[i]  = v_hit;
    assign hit[i] = ({1'b0, x_px} >= {1'b0, x_q}) &&
                    ({1'b0, x_px} <  ({1'b0, x_q} + 11'(OBJ_W))) &&
                    ({1'b0, y_px} >= {1'b0, y_q}) &&
                    ({1'b0, y_px} <  ({1'b0, y_q} + 11'(OBJ_H)));
  end

  // ---------------------------------------------------------------------------
  // Pixel colour; scanning from the top index down lets object 0 win overlaps.
  // ---------------------------------------------------------------------------
  logic [2:0] color_q, color_d;

  always_comb begin
    color_d = 3'd0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) color_d = 3'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) color_q <= 3'd0;
    else     color_q <= color_d;
  end

  // ---------------------------------------------------------------------------
  // Sound FSM.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    SND_IDLE = 1'b0,
    SND_PLAY = 1'b1
  } snd_state_t;

  snd_state_t       snd_q, snd_d;
  logic [1:0]       code_q, code_d;
  logic [SND_W-1:0] frames_q, frames_d;
  logic             mute_q, mute_d;

  always_comb begin
    snd_d    = snd_q;
    code_d   = code_q;
    frames_d = frames_q;
    if (frame_tick) begin
      if ((|hb) || (|vb)) begin
        code_d   = {|vb, |hb};
        frames_d = SND_W'(SND_FRAMES);
        snd_d    = SND_PLAY;
      end else if (snd_q == SND_PLAY) begin
        frames_d = frames_q - 1'b1;
        if (frames_q == SND_W'(1)) begin
          code_d = 2'b00;
          snd_d  = SND_IDLE;
        end
      end
    end
    // Derived from the next code so mute and code_sound change on the same edge.
    mute_d = (code_d == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      snd_q    <= SND_IDLE;
      code_q   <= 2'b00;
      frames_q <= '0;
      mute_q   <= 1'b1;
    end else begin
      snd_q    <= snd_d;
      code_q   <= code_d;
      frames_q <= frames_d;
      mute_q   <= mute_d;
    end
  end

  assign color_px   = color_q;
  assign code_sound = code_q;
  assign mute       = mute_q;
  assign vel        = vel_q;

endmodule
`default_nettype wire

// File: tb/tb_bounce_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bounce_engine                                             |
// | Description : Self-checking bench for bounce_engine. A behavioural model   |
// |               of object motion, speed and sound is advanced per frame;     |
// |               object placement is observed through color_px probes.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bounce_engine;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int N_OBJ      = 3;
  localparam int OBJ_W      = 32;
  localparam int OBJ_H      = 32;
  localparam int VEL_MAX    = 7;
  localparam int DEB_CYC    = 16;
  localparam int SND_FRAMES = 8;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [9:0] x_px = 10'd0;
  logic [9:0] y_px = 10'd0;
  logic       inc_vel = 1'b0;
  logic       dec_vel = 1'b0;
  logic [2:0] color_px;
  logic [1:0] code_sound;
  logic       mute;
  logic [3:0] vel;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int mx [N_OBJ];
  int my [N_OBJ];
  int mdx[N_OBJ];
  int mdy[N_OBJ];
  int mvel;
  int mcode;
  int mleft;

  bounce_engine #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .N_OBJ     (N_OBJ),
    .OBJ_W     (OBJ_W),
    .OBJ_H     (OBJ_H),
    .VEL_MAX   (VEL_MAX),
    .DEB_CYC   (DEB_CYC),
    .SND_FRAMES(SND_FRAMES)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .x_px      (x_px),
    .y_px      (y_px),
    .inc_vel   (inc_vel),
    .dec_vel   (dec_vel),
    .color_px  (color_px),
    .code_sound(code_sound),
    .mute      (mute),
    .vel       (vel)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_OBJ; i++) begin
      mx[i]  = 16 + 64 * i;
      my[i]  = 16 + 48 * i;
      mdx[i] = (i % 2 == 0) ? 1 : -1;
      mdy[i] = 1;
    end
    mvel  = 1;
    mcode = 0;
    mleft = 0;
  endtask

  // One axis of motion: travel by v, stop at [0, lim] and reverse on contact.
  task automatic move(inout int p, inout int d, input int lim, input int v, output bit b);
    b = 1'b0;
    if (d > 0) begin
      if (p + v >= lim) begin p = lim; d = -1; b = 1'b1; end
      else p = p + v;
    end else begin
      if (p < v) begin p = 0; d = 1; b = 1'b1; end
      else p = p - v;
    end
  endtask

  function automatic int model_color(int px, int py);
    for (int i = 0; i < N_OBJ; i++) begin
      if (px >= mx[i] && px < mx[i] + OBJ_W && py >= my[i] && py < my[i] + OBJ_H)
        return i + 1;
    end
    return 0;
  endfunction

  // Present the end-of-frame coordinate for 1..3 clocks (only one tick allowed).
  task automatic frame();
    int  hold;
    int  p, d;
    bit  hb, vb, b;
    hold = $urandom_range(1, 3);
    @(negedge clk);
    x_px = 10'(H_ACTIVE);
    y_px = 10'(V_ACTIVE);
    repeat (hold) @(negedge clk);
    x_px = 10'd0;
    y_px = 10'd0;
    hb = 1'b0;
    vb = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      p = mx[i]; d = mdx[i];
      move(p, d, H_ACTIVE - OBJ_W, mvel, b);
      mx[i] = p; mdx[i] = d; hb = hb | b;
      p = my[i]; d = mdy[i];
      move(p, d, V_ACTIVE - OBJ_H, mvel, b);
      my[i] = p; mdy[i] = d; vb = vb | b;
    end
    if (hb || vb) begin
      mcode = (vb ? 2 : 0) + (hb ? 1 : 0);
      mleft = SND_FRAMES;
    end else if (mcode != 0) begin
      mleft--;
      if (mleft == 0) mcode = 0;
    end
    @(negedge clk);
    check("code_sound", 16'(code_sound), 16'(mcode));
    check("mute", 16'(mute), 16'(mcode == 0));
  endtask

  task automatic probe_exp(input string tag, input int px, input int py, input int exp);
    @(negedge clk);
    x_px = 10'(px);
    y_px = 10'(py);
    @(negedge clk);
    check(tag, 16'(color_px), 16'(exp));
  endtask

  task automatic probe(input string tag, input int px, input int py);
    probe_exp(tag, px & 1023, py & 1023, model_color(px & 1023, py & 1023));
  endtask

  task automatic check_objects();
    for (int i = 0; i < N_OBJ; i++) begin
      probe("color_top_left", mx[i], my[i]);
      probe("color_left_out", mx[i] - 1, my[i]);
      probe("color_bot_right", mx[i] + OBJ_W - 1, my[i] + OBJ_H - 1);
      probe("color_right_out", mx[i] + OBJ_W, my[i]);
      probe("color_below_out", mx[i], my[i] + OBJ_H);
    end
  endtask

  // Hold the button(s) for len clocks, release, let the debouncer settle.
  task automatic press(input bit inc, input bit dec, input int len);
    @(negedge clk);
    inc_vel = inc;
    dec_vel = dec;
    repeat (len) @(negedge clk);
    inc_vel = 1'b0;
    dec_vel = 1'b0;
    repeat (6) @(negedge clk);
    if (len >= DEB_CYC) begin
      if (inc && !dec && mvel < VEL_MAX) mvel++;
      else if (dec && !inc && mvel > 0) mvel--;
    end
    check("vel", 16'(vel), 16'(mvel));
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_color", 16'(color_px), 16'd0);
    check("rst_code", 16'(code_sound), 16'd0);
    check("rst_mute", 16'(mute), 16'd1);
    check("rst_vel", 16'(vel), 16'd1);
    clr = 1'b0;

    // First frame at speed 1
    frame();
    probe_exp("obj0_at_17_17", 17, 17, 1);
    probe_exp("obj0_not_16_17", 16, 17, 0);
    probe_exp("obj0_not_17_16", 17, 16, 0);
    probe_exp("obj1_at_79_65", 79, 65, 2);
    probe_exp("obj1_not_78_65", 78, 65, 0);
    probe_exp("bg_0_479", 0, 479, 0);
    check_objects();

    // Speed saturation up and down
    for (int k = 0; k < 10; k++) press(1'b1, 1'b0, DEB_CYC + 3);
    check("vel_sat_hi", 16'(vel), 16'd7);
    for (int k = 0; k < 9; k++) press(1'b0, 1'b1, DEB_CYC + 3);
    check("vel_sat_lo", 16'(vel), 16'd0);
    for (int k = 0; k < SND_FRAMES + 1; k++) frame();
    check_objects();

    // Debounce boundaries and simultaneous presses
    press(1'b1, 1'b0, DEB_CYC - 1);
    press(1'b1, 1'b0, DEB_CYC);
    press(1'b1, 1'b1, DEB_CYC + 3);
    press(1'b0, 1'b1, DEB_CYC - 1);

    // Randomised operation at moderate-to-high speed
    for (int k = 0; k < 6; k++) press(1'b1, 1'b0, DEB_CYC + 2);
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 24);
      if (r == 0)      press(1'b1, 1'b0, $urandom_range(DEB_CYC - 2, DEB_CYC + 2));
      else if (r == 1) press(1'b0, 1'b1, $urandom_range(DEB_CYC - 2, DEB_CYC + 2));
      else if (r == 2) press(1'b1, 1'b1, DEB_CYC + 1);
      else begin
        frame();
        check_objects();
      end
    end

    // Reset in the middle of a debounce and possibly a sound
    @(negedge clk);
    inc_vel = 1'b1;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    check("midrst_color", 16'(color_px), 16'd0);
    check("midrst_code", 16'(code_sound), 16'd0);
    check("midrst_mute", 16'(mute), 16'd1);
    check("midrst_vel", 16'(vel), 16'd1);
    repeat (DEB_CYC - 1) @(negedge clk);
    inc_vel = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_vel_after", 16'(vel), 16'd1);
    frame();
    probe_exp("post_rst_obj0", 17, 17, 1);
    probe_exp("post_rst_obj1", 79, 65, 2);
    check_objects();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bounce_engine.md
BOUNCE_ENGINE -- requirements
Module: bounce_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 SHALL have parameter N_OBJ, default 2, number of bouncing objects (legal 1..4).
REQ-004 SHALL have parameter OBJ_W / OBJ_H, default 32 / 32, object size in pixels.
REQ-005 SHALL have parameter VEL_MAX, default 7, maximum speed in pixels per frame (at most 15).
REQ-006 SHALL have parameter DEB_CYC, default 120000, button debounce time in clk cycles.
REQ-007 SHALL have parameter SND_FRAMES, default 8, sound hold time in frames.
REQ-008 SHALL have port clk, input, 1, system clock (12 MHz).
REQ-009 SHALL have port clr, input, 1, reset: one clock, synchronous, active-high.
REQ-010 SHALL have ports x_px / y_px, input, 10 each, current pixel coordinate from the VGA controller.
REQ-011 SHALL have ports inc_vel / dec_vel, input, 1 each, raw asynchronous pushbuttons, active-high.
REQ-012 SHALL have port color_px, output, 3, RGB colour for the current pixel.
REQ-013 SHALL have port code_sound, output, 2, event sound code.
REQ-014 SHALL have port mute, output, 1, high when no sound is active.
REQ-015 SHALL have port vel, output, 4, current speed.

Function
REQ-016 SHALL generate frame_tick as a one-cycle pulse on the first clk where x_px==H_ACTIVE and y_px==V_ACTIVE; further cycles at that coordinate SHALL NOT re-pulse.
REQ-017 Each button SHALL pass through a 2-FF synchroniser, then a debounce FSM with states IDLE, COUNT and HELD.
- IDLE->COUNT when the input is high.
- COUNT->IDLE when the input drops.
- COUNT->HELD after DEB_CYC consecutive high cycles, emitting one 1-cycle pulse.
- HELD->IDLE when the input is low.
REQ-018 The speed register SHALL update on debounce pulses and saturate.
- inc pulse: +1, saturates at VEL_MAX.
- dec pulse: -1, saturates at 0.
- inc and dec in the same cycle: no change.
- Speed 0 freezes all objects.
REQ-019 Object positions SHALL use the speed value latched at frame_tick; a speed change takes effect from the next frame_tick.
REQ-020 Each object i SHALL hold x_pos[9:0], y_pos[9:0], dx, dy, updated only on frame_tick.
REQ-021 Horizontal update:
- Moving right: if x_pos+vel >= H_ACTIVE-OBJ_W, then x_pos = H_ACTIVE-OBJ_W, dx flips, hbounce. Otherwise x_pos += vel.
- Moving left: if x_pos < vel (11-bit compare), then x_pos = 0, dx flips, hbounce. Otherwise x_pos -= vel.
REQ-022 Vertical update SHALL match REQ-021 using y_pos, dy, V_ACTIVE-OBJ_H and vbounce.
REQ-023 Pixel-in-object test SHALL be x_pos<=x_px<x_pos+OBJ_W and y_pos<=y_px<y_pos+OBJ_H.
REQ-024 color_px SHALL be registered, with one clk latency from x_px/y_px.
- Colour of object i = i+1.
- Lowest index wins on overlap.
- Background = 3'b000.
REQ-025 The sound FSM SHALL have states IDLE and PLAY.
- On frame_tick with any bounce: code_sound = 01 (horizontal only), 10 (vertical only) or 11 (both/corner); frame counter loads SND_FRAMES; enters PLAY.
- A new bounce while in PLAY overwrites the code and reloads the counter.
- The counter decrements on each frame_tick without a bounce.
- At 0: code_sound = 00, return to IDLE.
REQ-026 mute SHALL equal (code_sound==2'b00), registered.
REQ-027 vel SHALL present the live speed register, not the latched speed.

Reset
REQ-028 On clr high at a clk edge, all outputs SHALL take these values:
- color_px = 0, code_sound = 0, mute = 1, vel = 1.
- Debounce FSMs IDLE, sound FSM IDLE, frame_tick edge detector cleared.
REQ-029 Object initial state after reset:
- x_pos = 16+64*i, y_pos = 16+48*i.
- dy = down.
- dx = right for even i, left for odd i.
REQ-030 clr asserted mid-frame or mid-debounce SHALL abort all activity; no pulse or bounce SHALL be emitted in the reset cycle.

Verification
REQ-031 Reset, then one frame_tick -> obj0 at (17,17), obj1 at (79,65); code_sound = 00, mute = 1.
REQ-032 inc_vel high for DEB_CYC+3 cycles, pressed 10 times -> vel = 7 (saturates); dec_vel pressed 9 times -> vel = 0; the following frame_tick leaves all positions unchanged.
REQ-033 Glitch of inc_vel high for DEB_CYC-1 cycles -> vel unchanged; inc and dec debounced pulses in the same cycle -> vel unchanged.
REQ-034 Force obj0 to x = 606, dx right, vel = 3 -> after frame_tick x = 608, dx = left, code_sound = 01, mute = 0; SND_FRAMES bounce-free ticks later -> code_sound = 00.
REQ-035 Force obj0 to (1,1), moving left/up, vel = 2 -> after frame_tick position (0,0), both directions flipped, code_sound = 11.
REQ-036 Place obj0 and obj1 overlapping at (100,100), sample x_px=110, y_px=110 -> color_px = 3'b001 one clk later; x_px = 0, y_px = 479 -> color_px = 3'b000.
